// File: rtl/i2c_sched.sv
`default_nettype none
// ============================================================================
// Module   : i2c_sched
// Purpose  : Round-robin scheduler sharing one I2C master among NREQ
//            single-byte requesters. Define I2C_SCHED_TIMEOUT_EN for a
//            done-timeout in XFER.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_sched #(
  parameter int NREQ    = 2,
  parameter int GAP_CYC = 4,
  parameter int TO_CYC  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 rsp_ack,
  output logic                 rsp_err,
  output logic                 m_start,
  output logic                 m_stop,
  output logic                 m_chk,
  output logic [7:0]           m_din,
  input  logic                 m_done,
  input  logic                 m_ack,
  input  logic [7:0]           m_dout
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam logic [IW:0]   c_NREQ     = (IW+1)'(NREQ);
  localparam logic [3:0]    c_GAP_LAST = 4'(GAP_CYC - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_START = 3'd1;
  localparam logic [2:0] c_XFER  = 3'd2;
  localparam logic [2:0] c_STOP  = 3'd3;
  localparam logic [2:0] c_GAP   = 3'd4;
  localparam logic [2:0] c_RSP   = 3'd5;

  logic [2:0]      r_state;
  logic [IW-1:0]   r_win;
  logic [IW-1:0]   r_last;
  logic            r_rw;
  logic [7:0]      r_din;
  logic [7:0]      r_rdata;
  logic            r_ack;
  logic [3:0]      r_gap;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW:0]     w_idx;
  logic            w_rw;
  logic [7:0]      w_wdata;
  logic [NREQ-1:0] w_onehot;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = {1'b0, r_last} + (IW+1)'(k);
      if (w_idx >= c_NREQ) w_idx = w_idx - c_NREQ;
      if (!w_found && req[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    w_rw     = 1'b0;
    w_wdata  = '0;
    w_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IW'(i)) begin
        w_rw    = req_rw[i];
        w_wdata = req_data[i*8 +: 8];
      end
      w_onehot[i] = (r_win == IW'(i));
    end
  end

`ifdef I2C_SCHED_TIMEOUT_EN
  localparam logic [7:0] c_TO_LAST = 8'(TO_CYC - 1);
  logic [7:0] r_to;
  logic       r_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_win   <= '0;
      r_last  <= IW'(NREQ - 1);
      r_rw    <= 1'b0;
      r_din   <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_gap   <= '0;
`ifdef I2C_SCHED_TIMEOUT_EN
      r_to    <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_win   <= w_win;
            r_rw    <= w_rw;
            r_din   <= w_wdata;
            r_state <= c_START;
          end
        end
        c_START: begin
`ifdef I2C_SCHED_TIMEOUT_EN
          r_to    <= '0;
`endif
          r_state <= c_XFER;
        end
        c_XFER: begin
          if (m_done) begin
            r_rdata <= r_rw ? 8'h00 : m_dout;
            r_ack   <= m_ack;
`ifdef I2C_SCHED_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            r_state <= c_STOP;
          end
`ifdef I2C_SCHED_TIMEOUT_EN
          else if (r_to == c_TO_LAST) begin
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= c_STOP;
          end else begin
            r_to <= r_to + 8'd1;
          end
`endif
        end
        c_STOP: begin
          r_gap   <= '0;
          r_state <= c_GAP;
        end
        c_GAP: begin
          if (r_gap == c_GAP_LAST) r_state <= c_RSP;
          else                     r_gap   <= r_gap + 4'd1;
        end
        c_RSP: begin
          r_last  <= r_win;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign gnt       = (r_state != c_IDLE) ? w_onehot : '0;
  assign rsp_valid = (r_state == c_RSP)  ? w_onehot : '0;
  assign rsp_data  = r_rdata;
  assign rsp_ack   = r_ack;
  assign m_start   = (r_state == c_START);
  assign m_stop    = (r_state == c_STOP);
  assign m_chk     = r_rw;
  assign m_din     = r_din;

`ifdef I2C_SCHED_TIMEOUT_EN
  assign rsp_err   = r_err;
`else
  // Timeout length is meaningless without the counter; error never raised.
  localparam logic c_TO_CFG = (TO_CYC > 0);
  assign rsp_err   = 1'b0 & c_TO_CFG;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_sched.sv
`default_nettype none
// Bench for i2c_sched: directed cases plus random traffic against a queue-based
// reference (round-robin order, master response, response timing).
module tb_i2c_sched;
  localparam int NREQ    = 2;
  localparam int GAP_CYC = 4;
`ifdef I2C_SCHED_TIMEOUT_EN
  localparam int TO_CYC  = 20;
`else
  localparam int TO_CYC  = 255;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [7:0]        rsp_data, m_din;
  logic              rsp_ack, rsp_err, m_start, m_stop, m_chk;
  logic              md = 1'b0, spur = 1'b0, m_ack = 1'b0;
  logic [7:0]        m_dout = '0;
  logic              m_done;
  assign m_done = md | spur;

  i2c_sched #(.NREQ(NREQ), .GAP_CYC(GAP_CYC), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
    .rsp_err(rsp_err), .m_start(m_start), .m_stop(m_stop), .m_chk(m_chk),
    .m_din(m_din), .m_done(m_done), .m_ack(m_ack), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         w;
    logic [7:0] data;
    logic       ack;
    logic       err;
    int         when;
  } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference state: last winner, fixed master behaviour for directed cases.
  int         mlast = NREQ - 1;
  int         fix_d = 0;
  logic [7:0] fix_dout = '0;
  logic       fix_ack = 1'b0;
  bit         no_done = 1'b0;
  int         gorder[$];
  int         start_cyc = 0;
  int         stops = 0;

  always @(negedge rst_n) mlast = NREQ - 1;

  function automatic bit held(input int w, input logic rw, input logic [7:0] din);
    return (m_chk === rw) && (m_din === din) && !m_stop && !m_start &&
           (gnt === NREQ'(1 << w)) && (rsp_valid === '0);
  endfunction

  // Master model + arbitration reference; pushes expected responses.
  initial begin : master
    int w, d, n;
    logic rw, ack, ok, aborted;
    logic [7:0] din, dout;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst_n && m_start) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[(mlast + k) % NREQ]) w = (mlast + k) % NREQ;
        check("start_has_req", 32'(w >= 0), 1);
        if (w < 0) w = 0;
        rw  = req_rw[w];
        din = req_data[8*w +: 8];
        check("gnt_at_start", gnt, 1 << w);
        check("m_chk_at_start", m_chk, rw);
        check("m_din_at_start", m_din, din);
        mlast = w;
        gorder.push_back(w);
        start_cyc = cyc;
        d    = (fix_d > 0) ? fix_d : $urandom_range(1, 10);
        dout = (fix_d > 0) ? fix_dout : 8'($urandom);
        ack  = (fix_d > 0) ? fix_ack : 1'($urandom);
        ok = 1'b1;
        aborted = 1'b0;
        if (no_done) begin
`ifdef I2C_SCHED_TIMEOUT_EN
          for (int i = 0; i < TO_CYC && !aborted; i++) begin
            @(posedge clk); #1;
            if (!rst_n) aborted = 1'b1;
            else ok &= held(w, rw, din);
          end
          if (!aborted) begin
            @(posedge clk); #1;
            check("to_stop", m_stop, 1);
            check("to_stop_cycle", cyc, start_cyc + TO_CYC + 1);
            e.w = w; e.data = 8'h00; e.ack = 1'b0; e.err = 1'b1;
            e.when = cyc + 1 + GAP_CYC;
            sbq.push_back(e);
          end
`else
          for (n = 0; n < 5000 && rst_n; n++) begin
            @(posedge clk); #1;
            if (rst_n) ok &= held(w, rw, din);
          end
          if (rst_n) check("xfer_wait_bound", n, 0);
          aborted = 1'b1;
`endif
        end else begin
          for (int i = 0; i < d && !aborted; i++) begin
            @(posedge clk); #1;
            if (!rst_n) aborted = 1'b1;
            else ok &= held(w, rw, din);
          end
          if (!aborted) begin
            md = 1'b1; m_dout = dout; m_ack = ack;
            @(posedge clk); #1;
            md = 1'b0; m_dout = 8'($urandom); m_ack = 1'($urandom);
            check("m_stop_after_done", m_stop, 1);
            e.w = w; e.data = rw ? 8'h00 : dout; e.ack = ack; e.err = 1'b0;
            e.when = cyc + 1 + GAP_CYC;
            sbq.push_back(e);
          end
        end
        check("xfer_hold", ok, 1);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT responds.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (m_stop) stops++;
      check("gnt_onehot0", 32'($countones(gnt) <= 1), 1);
      if (rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sbq.pop_front();
          check("rsp_valid", rsp_valid, 1 << e.w);
          check("rsp_data", rsp_data, e.data);
          check("rsp_ack", rsp_ack, e.ack);
          check("rsp_err", rsp_err, e.err);
          check("rsp_cycle", cyc, e.when);
        end
      end
    end
  end

  task automatic post(input int i, input logic rw, input logic [7:0] d);
    req_rw[i] = rw;
    req_data[8*i +: 8] = d;
    req[i] = 1'b1;
  endtask

  task automatic wait_rsp(input int i, input string name);
    int n;
    n = 0;
    while (!rsp_valid[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[i]) check(name, rsp_valid, 1 << i);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_ack"}, rsp_ack, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_m_start"}, m_start, 0);
    check({tag, "_m_stop"}, m_stop, 0);
    check({tag, "_m_chk"}, m_chk, 0);
    check({tag, "_m_din"}, m_din, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin : stim
    int raise_cyc, s0, n;
    logic [NREQ-1:0] busy;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single write; m_done held through the START cycle must be ignored.
    @(negedge clk);
    fix_d = 18; fix_ack = 1'b1; fix_dout = 8'h3C;
    post(0, 1'b1, 8'hCC);
    spur = 1'b1;
    raise_cyc = cyc;
    @(negedge clk);
    @(negedge clk);
    spur = 1'b0;
    check("t1_start_latency", start_cyc, raise_cyc + 1);
    wait_rsp(0, "t1_rsp_timeout");
    req[0] = 1'b0;
    check("t1_rsp_data", rsp_data, 8'h00);

    // Single read from requester 1.
    @(negedge clk);
    fix_d = 5; fix_dout = 8'hA5; fix_ack = 1'b0;
    post(1, 1'b0, 8'h77);
    wait_rsp(1, "t2_rsp_timeout");
    req[1] = 1'b0;
    check("t2_rsp_data", rsp_data, 8'hA5);
    check("t2_rsp_valid", rsp_valid, 2'b10);

    // Contention: both held for three transactions.
    @(negedge clk);
    gorder.delete();
    fix_d = 3;
    post(0, 1'b1, 8'($urandom));
    post(1, 1'b0, 8'($urandom));
    for (int t = 0; t < 3; t++) begin
      n = 0;
      while (rsp_valid == '0 && n < 2000) begin @(negedge clk); n++; end
      if (t == 2) req = '0;
      @(negedge clk);
    end
    check("t3_grants", gorder.size(), 3);
    if (gorder.size() == 3) begin
      check("t3_order0", gorder[0], 0);
      check("t3_order1", gorder[1], 1);
      check("t3_order2", gorder[2], 0);
    end
    fix_d = 0;

    // Master never completes.
    @(negedge clk);
    no_done = 1'b1;
    post(0, 1'b1, 8'h11);
`ifdef I2C_SCHED_TIMEOUT_EN
    wait_rsp(0, "t4_rsp_timeout");
    req[0] = 1'b0;
    check("t4_err", rsp_err, 1);
    check("t4_data", rsp_data, 0);
    @(negedge clk);
    post(0, 1'b1, 8'h22);
    repeat (6) @(negedge clk);
`else
    s0 = stops;
    repeat (1000) @(negedge clk);
    check("t4_stuck_gnt", gnt, 2'b01);
    check("t4_no_stop", stops, s0);
`endif

    // Asynchronous reset mid-XFER; requester 0 first afterwards.
    post(1, 1'b1, 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    @(negedge clk);
    @(negedge clk);
    no_done = 1'b0;
    gorder.delete();
    rst_n = 1'b1;
    wait_rsp(0, "t5_rsp0_timeout");
    req[0] = 1'b0;
    wait_rsp(1, "t5_rsp1_timeout");
    req[1] = 1'b0;
    check("t5_grants", gorder.size(), 2);
    if (gorder.size() == 2) begin
      check("t5_first", gorder[0], 0);
      check("t5_second", gorder[1], 1);
    end

    // Random traffic, including early request drops after grant.
    busy = '0;
    for (int c = 0; c < 3200; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          busy[i] = 1'b0;
          req[i]  = 1'b0;
        end else if (req[i] && gnt[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b0;
        end
        if (!busy[i] && c < 3000 && $urandom_range(0, 3) == 0) begin
          busy[i] = 1'b1;
          post(i, 1'($urandom), 8'($urandom));
        end
      end
    end
    n = 0;
    while (busy != '0 && n < 2000) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (rsp_valid[i]) begin busy[i] = 1'b0; req[i] = 1'b0; end
      n++;
    end
    check("drain_busy", busy, 0);
    repeat (4) @(negedge clk);
    check("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_sched.md
# i2c_sched

Round-robin scheduler that shares one I2C master (start/stop/chk/din/dout/done/ack interface) between NREQ requesters. Each requester posts a single-byte read or write; the scheduler grants one requester at a time, sequences the master's start pulse, data/direction hold, done wait and stop pulse, and returns read data and ACK status to the winner. It sits between the client logic and `i2c_top` and is the only block that drives the master's control inputs.

## Interface
- NREQ, 2: number of requesters, 2..4.
- GAP_CYC, 4: idle cycles after stop before the next start (bus-free time), 1..15.
- TO_CYC, 255: done-timeout in cycles (used only with the timeout macro), 1..255.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; held until own rsp_valid.
- req_rw  in  NREQ  per-requester direction: 1 = write, 0 = read (same sense as master chk).
- req_data  in  8*NREQ  write byte; requester i occupies bits [8i+7:8i].
- gnt  out  NREQ  one-hot grant, high from ARB exit through RSP.
- rsp_valid  out  NREQ  one-cycle completion pulse to the granted requester.
- rsp_data  out  8  read byte (m_dout captured at done); 0 for writes.
- rsp_ack  out  1  m_ack captured at done; valid with rsp_valid.
- rsp_err  out  1  1 = timeout abort; valid with rsp_valid.
- m_start  out  1  one-cycle start pulse to master.
- m_stop  out  1  one-cycle stop pulse to master.
- m_chk  out  1  direction to master, held for the whole transaction.
- m_din  out  8  write byte to master, held for the whole transaction.
- m_done  in  1  master transaction complete (sampled level).
- m_ack  in  1  master ACK status.
- m_dout  in  8  master read data.

## Operation
- States: IDLE, START, XFER, STOP, GAP, RSP.
- IDLE: if any req bit set, select winner by round robin, searching from (last_grant+1) mod NREQ upward; latch winner index, req_rw and req_data slice; assert gnt; go START. No req: stay.
- START: m_start=1 for exactly one cycle; m_chk/m_din driven from latched values; go XFER.
- XFER: wait for m_done=1; on that cycle capture m_dout (read) or 0 (write) into rsp_data and m_ack into rsp_ack; go STOP.
- STOP: m_stop=1 for one cycle; go GAP.
- GAP: count GAP_CYC cycles with all master controls low except m_chk/m_din held; go RSP.
- RSP: rsp_valid[winner]=1 one cycle; last_grant<=winner; gnt cleared on exit; go IDLE.
- Dropping req after grant does not abort; transaction completes and rsp_valid still fires.
- Requests arriving mid-transaction wait; no preemption.
- Reset (any state): all outputs 0 immediately, state IDLE, last_grant=NREQ-1 so requester 0 has first priority. A master transaction in flight is abandoned without stop; master reset is the integrator's responsibility.

## Timing
- Reset values: gnt=0, rsp_valid=0, rsp_data=0, rsp_ack=0, rsp_err=0, m_start=0, m_stop=0, m_chk=0, m_din=0.
- req sampled in IDLE at cycle N -> gnt and m_start at N+1.
- m_done seen at cycle D -> m_stop at D+1 -> rsp_valid at D+2+GAP_CYC.
- Minimum turnaround: rsp_valid cycle R -> next m_start earliest at R+2.
- m_done high in START cycle is ignored (only XFER samples it).

## Configuration
- I2C_SCHED_TIMEOUT_EN defined: XFER counts cycles; if m_done not seen after TO_CYC cycles, go STOP with rsp_err=1, rsp_data=0, rsp_ack=0. Stop pulse and gap still issued.
- Not defined: no counter; XFER waits indefinitely; rsp_err tied 0.

## Test plan
- Single write: req[0]=1, rw=1, data 8'hCC, master done after 18 cycles, ack=1 -> m_start 1 cycle after req, m_din=8'hCC/m_chk=1 held, m_stop at done+1, rsp_valid[0] at done+2+GAP_CYC, rsp_ack=1.
- Single read: req[1]=1, rw=0, m_dout=8'hA5 at done -> rsp_data=8'hA5, m_chk=0 throughout, rsp_valid[1] only.
- Contention: req=2'b11 held continuously, three transactions -> grant order 0,1,0; never two gnt bits high.
- Timeout (macro on, TO_CYC=20): m_done never asserted -> m_stop at cycle 21 after start, rsp_err=1, rsp_data=0; macro off -> FSM stays in XFER for 1000 cycles.
- Reset mid-XFER: rst_n low for 2 cycles -> all outputs 0 asynchronously; after release, req[1] pending is granted before req[0] only if req[0] absent (requester 0 first otherwise).
